// File: rtl/router_register_p.sv
// Router data register: header latch, payload check accumulation, FIFO-full byte capture,
// and per-packet check/length error detection with a saturating error counter.
module router_register_p #(
  parameter int unsigned DW        = 8,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned CHK_MODE  = 0,
  parameter int unsigned LEN_CHECK = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          packet_valid,
  input  logic [DW-1:0] datain,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          lfd_state,
  input  logic          rst_int_reg,
  output logic [DW-1:0] dout,
  output logic          err,
  output logic          len_err,
  output logic          parity_done,
  output logic          low_packet_valid,
  output logic [7:0]    err_cnt
);

  localparam int unsigned LW = DW - ADDR_W;

  logic [DW-1:0] hdr_reg;
  logic [DW-1:0] full_byte;
  logic [DW-1:0] chk_int;
  logic [DW-1:0] chk_rx;
  logic [LW:0]   pay_cnt;
  logic          parity_done_d1;

  logic start;
  logic evaluate;
  logic err_next;
  logic len_next;

  function automatic logic [DW-1:0] chk_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (CHK_MODE == 1) return a + b;
    else return a ^ b;
  endfunction

  always_comb begin
    start    = detect_add & packet_valid;
    // Evaluate exactly once, on the cycle after parity_done rises.
    evaluate = parity_done & ~parity_done_d1 & ~start;
    err_next = (chk_int != chk_rx);
    len_next = (LEN_CHECK != 0) && (pay_cnt != {1'b0, hdr_reg[DW-1:ADDR_W]});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout             <= '0;
      hdr_reg          <= '0;
      full_byte        <= '0;
      chk_int          <= '0;
      chk_rx           <= '0;
      pay_cnt          <= '0;
      err              <= 1'b0;
      len_err          <= 1'b0;
      parity_done      <= 1'b0;
      parity_done_d1   <= 1'b0;
      low_packet_valid <= 1'b0;
      err_cnt          <= '0;
    end else begin
      parity_done_d1 <= parity_done;

      if (start) begin
        hdr_reg <= datain;
        chk_int <= '0;
        pay_cnt <= '0;
      end else if (lfd_state) begin
        chk_int <= chk_f(chk_int, hdr_reg);
      end else if (ld_state && packet_valid && !full_state) begin
        chk_int <= chk_f(chk_int, datain);
        if (pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
      end

      if (lfd_state) dout <= hdr_reg;
      else if (ld_state && !fifo_full) dout <= datain;
      else if (laf_state) dout <= full_byte;

      if (ld_state && fifo_full) full_byte <= datain;

      if (rst_int_reg) low_packet_valid <= 1'b0;
      else if (ld_state && !packet_valid) low_packet_valid <= 1'b1;

      // A new header wins over any check-byte capture in the same cycle.
      if (start) begin
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
      end else begin
        if (ld_state && !packet_valid && !fifo_full) begin
          chk_rx      <= datain;
          parity_done <= 1'b1;
        end else if (laf_state && low_packet_valid && !parity_done) begin
          chk_rx      <= full_byte;
          parity_done <= 1'b1;
        end
        if (evaluate) begin
          err     <= err_next;
          len_err <= len_next;
          if ((err_next || len_next) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_register_p.sv
// Directed bench for router_register_p: default, LEN_CHECK=0 and 16-bit checksum instances.
module tb_router_register_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        packet_valid, fifo_full, detect_add, ld_state, laf_state;
  logic        full_state, lfd_state, rst_int_reg;
  logic [15:0] din;

  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;
  logic        err0, len_err0, pd0, lpv0;
  logic        err1, len_err1, pd1, lpv1;
  logic        err2, len_err2, pd2, lpv2;
  logic [7:0]  cnt0, cnt1, cnt2;

  logic [15:0] pay [32];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  router_register_p u0 (
    .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(din[7:0]),
    .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .rst_int_reg(rst_int_reg), .dout(dout0), .err(err0), .len_err(len_err0),
    .parity_done(pd0), .low_packet_valid(lpv0), .err_cnt(cnt0)
  );

  router_register_p #(.LEN_CHECK(0)) u1 (
    .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(din[7:0]),
    .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .rst_int_reg(rst_int_reg), .dout(dout1), .err(err1), .len_err(len_err1),
    .parity_done(pd1), .low_packet_valid(lpv1), .err_cnt(cnt1)
  );

  router_register_p #(.DW(16), .CHK_MODE(1)) u2 (
    .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(din),
    .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .rst_int_reg(rst_int_reg), .dout(dout2), .err(err2), .len_err(len_err2),
    .parity_done(pd2), .low_packet_valid(lpv2), .err_cnt(cnt2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    packet_valid = 0; fifo_full = 0; detect_add = 0; ld_state = 0; laf_state = 0;
    full_state = 0; lfd_state = 0; rst_int_reg = 0; din = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 0;
    step();
    reset = 1;
  endtask

  function automatic logic [7:0] exp_xor(input logic [7:0] hdr, input int n);
    logic [7:0] p = hdr;
    for (int i = 0; i < n; i++) p = p ^ pay[i][7:0];
    return p;
  endfunction

  function automatic logic [15:0] exp_sum16(input logic [15:0] hdr, input int n);
    logic [15:0] s = hdr;
    for (int i = 0; i < n; i++) s = s + pay[i];
    return s;
  endfunction

  // Header, lfd, n payload beats, then the check byte; with ff set the check byte goes
  // through full_byte and is released in a laf cycle.
  task automatic send_pkt(input logic [15:0] hdr, input int n, input logic [15:0] chk,
                          input logic ff);
    detect_add = 1; packet_valid = 1; din = hdr;
    step();
    detect_add = 0; lfd_state = 1;
    step();
    lfd_state = 0; ld_state = 1;
    for (int i = 0; i < n; i++) begin
      din = pay[i];
      step();
    end
    packet_valid = 0; din = chk; fifo_full = ff;
    step();
    ld_state = 0; fifo_full = 0; din = '0;
    if (ff) begin
      laf_state = 1;
      step();
      laf_state = 0;
    end
  endtask

  task automatic finish_pkt;
    rst_int_reg = 1;
    step();
    rst_int_reg = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (dout0 !== 8'h00) $display("FAIL reset_dout got %h want 00", dout0); else passes++;
    checks++; if (err0 !== 1'b0) $display("FAIL reset_err got %b want 0", err0); else passes++;
    checks++; if (len_err0 !== 1'b0) $display("FAIL reset_len_err got %b want 0", len_err0);
    else passes++;
    checks++; if (pd0 !== 1'b0) $display("FAIL reset_parity_done got %b want 0", pd0); else passes++;
    checks++; if (lpv0 !== 1'b0) $display("FAIL reset_lpv got %b want 0", lpv0); else passes++;
    checks++; if (cnt0 !== 8'd0) $display("FAIL reset_err_cnt got %0d want 0", cnt0); else passes++;
  endtask

  task automatic test_good_parity;
    logic [7:0] chk;
    do_reset();
    for (int i = 0; i < 14; i++) pay[i] = 16'($urandom_range(0, 255));
    chk = exp_xor(8'h3A, 14);
    send_pkt(16'h003A, 14, {8'h00, chk}, 1'b0);
    checks++; if (pd0 !== 1'b1) $display("FAIL good_pd got %b want 1", pd0); else passes++;
    checks++; if (dout0 !== chk) $display("FAIL good_dout got %h want %h", dout0, chk); else passes++;
    checks++; if (lpv0 !== 1'b1) $display("FAIL good_lpv got %b want 1", lpv0); else passes++;
    finish_pkt();
    checks++; if (err0 !== 1'b0) $display("FAIL good_err got %b want 0", err0); else passes++;
    checks++; if (len_err0 !== 1'b0) $display("FAIL good_len_err got %b want 0", len_err0);
    else passes++;
    checks++; if (cnt0 !== 8'd0) $display("FAIL good_cnt got %0d want 0", cnt0); else passes++;
    checks++; if (lpv0 !== 1'b0) $display("FAIL good_lpv_clr got %b want 0", lpv0); else passes++;
  endtask

  task automatic test_bad_parity;
    logic [7:0] chk;
    do_reset();
    for (int i = 0; i < 20; i++) pay[i] = 16'($urandom_range(0, 255));
    chk = exp_xor(8'h52, 20) ^ 8'h5A;
    send_pkt(16'h0052, 20, {8'h00, chk}, 1'b0);
    checks++; if (pd0 !== 1'b1 || err0 !== 1'b0)
      $display("FAIL bad_pd_edge got pd=%b err=%b want pd=1 err=0", pd0, err0);
    else passes++;
    finish_pkt();
    checks++; if (err0 !== 1'b1) $display("FAIL bad_err got %b want 1", err0); else passes++;
    checks++; if (cnt0 !== 8'd1) $display("FAIL bad_cnt got %0d want 1", cnt0); else passes++;
    step();
    checks++; if (err0 !== 1'b1 || cnt0 !== 8'd1)
      $display("FAIL bad_hold got err=%b cnt=%0d want err=1 cnt=1", err0, cnt0);
    else passes++;
  endtask

  task automatic test_fifo_full;
    logic [7:0] chk;
    do_reset();
    pay[0] = 16'h11; pay[1] = 16'h22; pay[2] = 16'h47;
    chk = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h47;
    detect_add = 1; packet_valid = 1; din = 16'h000D;
    step();
    detect_add = 0; lfd_state = 1;
    step();
    lfd_state = 0; ld_state = 1;
    for (int i = 0; i < 3; i++) begin
      din = pay[i];
      step();
    end
    packet_valid = 0; din = {8'h00, chk}; fifo_full = 1;
    step();
    checks++; if (dout0 !== 8'h47) $display("FAIL ff_hold got %h want 47", dout0); else passes++;
    checks++; if (pd0 !== 1'b0) $display("FAIL ff_pd_early got %b want 0", pd0); else passes++;
    ld_state = 0; fifo_full = 0; din = '0; laf_state = 1;
    step();
    laf_state = 0;
    checks++; if (dout0 !== chk) $display("FAIL ff_laf_dout got %h want %h", dout0, chk);
    else passes++;
    checks++; if (pd0 !== 1'b1) $display("FAIL ff_pd got %b want 1", pd0); else passes++;
    finish_pkt();
    checks++; if (err0 !== 1'b0) $display("FAIL ff_err got %b want 0", err0); else passes++;
  endtask

  task automatic test_len_err;
    do_reset();
    for (int i = 0; i < 6; i++) pay[i] = 16'(8'h30 + i);
    send_pkt(16'h0015, 6, {8'h00, exp_xor(8'h15, 6)}, 1'b0);
    finish_pkt();
    checks++; if (err0 !== 1'b0) $display("FAIL len_err0_err got %b want 0", err0); else passes++;
    checks++; if (len_err0 !== 1'b1) $display("FAIL len_len_err got %b want 1", len_err0);
    else passes++;
    checks++; if (cnt0 !== 8'd1) $display("FAIL len_cnt got %0d want 1", cnt0); else passes++;
    checks++; if (len_err1 !== 1'b0) $display("FAIL len_nochk got %b want 0", len_err1);
    else passes++;
    checks++; if (cnt1 !== 8'd0) $display("FAIL len_nochk_cnt got %0d want 0", cnt1); else passes++;
  endtask

  task automatic test_len_zero;
    do_reset();
    send_pkt(16'h0003, 0, 16'h0003, 1'b0);
    finish_pkt();
    checks++; if (err0 !== 1'b0 || len_err0 !== 1'b0)
      $display("FAIL len0 got err=%b len_err=%b want 0 0", err0, len_err0);
    else passes++;
  endtask

  task automatic test_checksum16;
    logic [15:0] chk;
    do_reset();
    pay[0] = 16'hF00D; pay[1] = 16'h8001; pay[2] = 16'h1234; pay[3] = 16'hABCD;
    chk = exp_sum16(16'h0011, 4);
    send_pkt(16'h0011, 4, chk, 1'b0);
    finish_pkt();
    checks++; if (pd2 !== 1'b1 || err2 !== 1'b0 || len_err2 !== 1'b0)
      $display("FAIL sum16_good got pd=%b err=%b len=%b want 1 0 0", pd2, err2, len_err2);
    else passes++;
    send_pkt(16'h0011, 4, chk ^ 16'h0100, 1'b0);
    finish_pkt();
    checks++; if (err2 !== 1'b1 || cnt2 !== 8'd1)
      $display("FAIL sum16_bad got err=%b cnt=%0d want 1 1", err2, cnt2);
    else passes++;
    detect_add = 1; packet_valid = 1; din = 16'h0011;
    step();
    detect_add = 0; lfd_state = 1;
    step();
    lfd_state = 0; ld_state = 1; din = pay[0];
    step();
    din = pay[1];
    step();
    checks++; if (dout2 !== 16'h8001) $display("FAIL sum16_mid got %h want 8001", dout2);
    else passes++;
    reset = 0;
    step();
    reset = 1; idle_inputs();
    checks++; if (dout2 !== 16'h0 || cnt2 !== 8'd0 || pd2 !== 1'b0 || err2 !== 1'b0
                  || lpv2 !== 1'b0 || len_err2 !== 1'b0)
      $display("FAIL sum16_rst got dout=%h cnt=%0d pd=%b err=%b want all 0",
               dout2, cnt2, pd2, err2);
    else passes++;
  endtask

  task automatic test_saturate;
    do_reset();
    for (int k = 0; k < 260; k++) begin
      send_pkt(16'h0000, 0, 16'h0001, 1'b0);
      finish_pkt();
      if (k == 254) begin
        checks++; if (cnt0 !== 8'd255) $display("FAIL sat_255 got %0d want 255", cnt0);
        else passes++;
      end
    end
    checks++; if (cnt0 !== 8'd255) $display("FAIL sat_260 got %0d want 255", cnt0); else passes++;
    checks++; if (err0 !== 1'b1) $display("FAIL sat_err got %b want 1", err0); else passes++;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_good_parity();
    test_bad_parity();
    test_fifo_full();
    test_len_err();
    test_len_zero();
    test_checksum16();
    test_saturate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
